// File: rtl/conv_window_sequencer.sv
// Sliding K x K window builder for the serial convolution engine: buffers K-1 rows,
// issues one engine run per complete window and forwards each result downstream.
module conv_window_sequencer #(
    parameter int K     = 3,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pix_valid,
    input  logic [7:0]                   pix_data,
    output logic                         pix_ready,
    output logic [K-1:0][K-1:0][7:0]     win_out,
    output logic                         conv_start,
    input  logic                         conv_done,
    input  logic [7:0]                   conv_pixel,
    output logic                         conv_clear,
    output logic                         res_valid,
    output logic [7:0]                   res_data,
    output logic [$clog2(IMG_W)-1:0]     res_x,
    output logic [$clog2(IMG_H)-1:0]     res_y,
    input  logic                         res_ready,
    output logic                         frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] C_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] R_MAX = RW'(IMG_H - 1);
    localparam logic [CW-1:0] C_KM1 = CW'(K - 1);
    localparam logic [RW-1:0] R_KM1 = RW'(K - 1);

    typedef enum logic [2:0] {
        FILL,
        START,
        WAIT,
        CLEAR,
        OUT
    } state_t;

    state_t                          state_q, state_d;
    logic [CW-1:0]                   c_q, c_d;
    logic [RW-1:0]                   r_q, r_d;
    logic [K-1:0][K-1:0][7:0]        win_q, win_d;
    // line_q[j][col] holds row (r-K+1+j) of the current frame at that column
    logic [K-2:0][IMG_W-1:0][7:0]    line_q, line_d;
    logic [7:0]                      res_data_q, res_data_d;
    logic [CW-1:0]                   res_x_q, res_x_d;
    logic [RW-1:0]                   res_y_q, res_y_d;
    logic                            last_q, last_d;

    always_comb begin
        state_d    = state_q;
        c_d        = c_q;
        r_d        = r_q;
        win_d      = win_q;
        line_d     = line_q;
        res_data_d = res_data_q;
        res_x_d    = res_x_q;
        res_y_d    = res_y_q;
        last_d     = last_q;
        pix_ready  = 1'b0;
        conv_start = 1'b0;
        conv_clear = 1'b0;
        res_valid  = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            FILL: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    for (int y = 0; y < K; y++) begin
                        for (int x = 0; x < K - 1; x++) begin
                            win_d[y][x] = win_q[y][x+1];
                        end
                    end
                    for (int j = 0; j < K - 1; j++) begin
                        win_d[j][K-1] = line_q[j][c_q];
                    end
                    win_d[K-1][K-1] = pix_data;

                    for (int j = 0; j < K - 2; j++) begin
                        line_d[j][c_q] = line_q[j+1][c_q];
                    end
                    line_d[K-2][c_q] = pix_data;

                    if (c_q == C_MAX) begin
                        c_d = '0;
                        r_d = (r_q == R_MAX) ? '0 : r_q + RW'(1);
                    end else begin
                        c_d = c_q + CW'(1);
                    end

                    // Windows whose left edge wraps from the previous row are skipped
                    if (r_q >= R_KM1 && c_q >= C_KM1) begin
                        state_d = START;
                        res_x_d = c_q - C_KM1;
                        res_y_d = r_q - R_KM1;
                        last_d  = (r_q == R_MAX) && (c_q == C_MAX);
                    end
                end
            end
            START: begin
                conv_start = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (conv_done) begin
                    res_data_d = conv_pixel;
                    state_d    = CLEAR;
                end
            end
            CLEAR: begin
                conv_clear = 1'b1;
                state_d    = OUT;
            end
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = FILL;
                    if (last_q) begin
                        frame_done = 1'b1;
                        r_d        = '0;
                        c_d        = '0;
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FILL;
            c_q        <= '0;
            r_q        <= '0;
            win_q      <= '0;
            line_q     <= '0;
            res_data_q <= '0;
            res_x_q    <= '0;
            res_y_q    <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            r_q        <= r_d;
            win_q      <= win_d;
            line_q     <= line_d;
            res_data_q <= res_data_d;
            res_x_q    <= res_x_d;
            res_y_q    <= res_y_d;
            last_q     <= last_d;
        end
    end

    assign win_out  = win_q;
    assign res_data = res_data_q;
    assign res_x    = res_x_q;
    assign res_y    = res_y_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench for conv_window_sequencer on a 4x4 image with a 3x3 window,
// with a cycle-stepped engine and downstream model.
module tb_conv_window_sequencer;

    localparam int K     = 3;
    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int WW    = K * K * 8;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        pix_valid;
    logic [7:0]                  pix_data;
    logic                        pix_ready;
    logic [K-1:0][K-1:0][7:0]    win_out;
    logic                        conv_start;
    logic                        conv_done;
    logic [7:0]                  conv_pixel;
    logic                        conv_clear;
    logic                        res_valid;
    logic [7:0]                  res_data;
    logic [$clog2(IMG_W)-1:0]    res_x;
    logic [$clog2(IMG_H)-1:0]    res_y;
    logic                        res_ready;
    logic                        frame_done;

    conv_window_sequencer #(.K(K), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .win_out    (win_out),
        .conv_start (conv_start),
        .conv_done  (conv_done),
        .conv_pixel (conv_pixel),
        .conv_clear (conv_clear),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_x      (res_x),
        .res_y      (res_y),
        .res_ready  (res_ready),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Hand-computed windows of a 1..16 frame, listed [y][x] row-major
    int win_tbl[4][9] = '{'{1, 2, 3, 5, 6, 7, 9, 10, 11},
                          '{2, 3, 4, 6, 7, 8, 10, 11, 12},
                          '{5, 6, 7, 9, 10, 11, 13, 14, 15},
                          '{6, 7, 8, 10, 11, 12, 14, 15, 16}};
    int trig_tbl[4] = '{11, 12, 15, 16};
    int x_tbl[4]    = '{0, 1, 0, 1};
    int y_tbl[4]    = '{0, 0, 1, 1};

    int cycle = 0;
    int pix_idx, busy_cnt, start_idx, done_idx, res_idx, clear_cnt, fd_cnt;
    int hold_left, last_acc_val, acc13_cycle;
    bit acc_pend, done_last, out_acc_last;
    logic [WW-1:0] held_win;

    task automatic checkOutput(input string tag, input logic [WW-1:0] actual,
                               input logic [WW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Frame f of a stream carries pixels 1..16 offset by 100*f
    function automatic logic [7:0] pixValue(input int i);
        return 8'((i % 16) + 1 + 100 * (i / 16));
    endfunction

    function automatic logic [WW-1:0] expWindow(input int w);
        logic [WW-1:0] v = '0;
        for (int k = 0; k < K * K; k++) begin
            v[k*8 +: 8] = 8'(win_tbl[w % 4][k] + 100 * (w / 4));
        end
        return v;
    endfunction

    task automatic stepCycle(input int npix, input int delay);
        @(posedge clk);
        cycle++;
        #1;
        if (acc_pend) begin
            pix_idx++;
            acc_pend = 1'b0;
        end
        pix_valid = (pix_idx < npix);
        pix_data  = pixValue(pix_idx);
        conv_done = 1'b0;
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                conv_done  = 1'b1;
                conv_pixel = 8'(50 + 10 * done_idx);
                done_idx++;
            end
        end
        res_ready = (hold_left == 0);
        #1;
        if (out_acc_last) checkOutput("ready_after_out", WW'(pix_ready), WW'(1));
        out_acc_last = 1'b0;
        if (busy_cnt > 0) begin
            checkOutput("win_held", win_out, held_win);
            checkOutput("ready_low_wait", WW'(pix_ready), WW'(0));
        end
        if (conv_clear) begin
            checkOutput("clear_after_done", WW'(done_last), WW'(1));
            clear_cnt++;
        end
        done_last = conv_done;
        if (conv_start) begin
            checkOutput("start_trigger", WW'(last_acc_val),
                        WW'(trig_tbl[start_idx % 4] + 100 * (start_idx / 4)));
            checkOutput("win_at_start", win_out, expWindow(start_idx));
            held_win = win_out;
            busy_cnt = delay;
            start_idx++;
        end
        if (res_valid) begin
            checkOutput("res_data", WW'(res_data), WW'(8'(50 + 10 * res_idx)));
            checkOutput("res_x", WW'(res_x), WW'(x_tbl[res_idx % 4]));
            checkOutput("res_y", WW'(res_y), WW'(y_tbl[res_idx % 4]));
            if (res_ready) begin
                checkOutput("frame_done", WW'(frame_done), WW'(res_idx % 4 == 3));
                if (frame_done) fd_cnt++;
                res_idx++;
                out_acc_last = 1'b1;
            end else begin
                checkOutput("ready_low_out", WW'(pix_ready), WW'(0));
                hold_left--;
            end
        end else if (frame_done) begin
            checkOutput("frame_done_idle", WW'(frame_done), WW'(0));
        end
        if (pix_valid && pix_ready) begin
            acc_pend     = 1'b1;
            last_acc_val = int'(pix_data);
            if (int'(pix_data) % 100 == 13) acc13_cycle = cycle;
            if (int'(pix_data) % 100 == 14)
                checkOutput("gap_13_14", WW'(cycle - acc13_cycle), WW'(1));
        end
    endtask

    // Streams npix pixels; stop_wait>0 returns that many cycles into the first WAIT
    task automatic applyStimulus(input int npix, input int delay, input int hold,
                                 input int exp_win, input int stop_wait);
        int n = 0;
        pix_idx = 0; acc_pend = 1'b0; busy_cnt = 0; start_idx = 0; done_idx = 0;
        res_idx = 0; clear_cnt = 0; fd_cnt = 0; hold_left = hold; done_last = 1'b0;
        out_acc_last = 1'b0; last_acc_val = 0; acc13_cycle = 0;
        forever begin
            stepCycle(npix, delay);
            n++;
            if (stop_wait > 0 && start_idx == 1 && busy_cnt == delay - stop_wait) return;
            if (stop_wait == 0 && res_idx == exp_win) break;
            if (n >= 2000) begin
                checkOutput("stream_timeout", WW'(n), WW'(0));
                break;
            end
        end
        stepCycle(npix, delay);
        checkOutput("start_count", WW'(start_idx), WW'(exp_win));
        checkOutput("clear_count", WW'(clear_cnt), WW'(exp_win));
        checkOutput("frame_done_count", WW'(fd_cnt), WW'(exp_win / 4));
        checkOutput("pixels_accepted", WW'(pix_idx + int'(acc_pend)), WW'(npix));
    endtask

    task automatic checkResetOutputs(input string phase);
        checkOutput({phase, "_win_out"}, win_out, WW'(0));
        checkOutput({phase, "_res_data"}, WW'(res_data), WW'(0));
        checkOutput({phase, "_res_x"}, WW'(res_x), WW'(0));
        checkOutput({phase, "_res_y"}, WW'(res_y), WW'(0));
        checkOutput({phase, "_conv_start"}, WW'(conv_start), WW'(0));
        checkOutput({phase, "_conv_clear"}, WW'(conv_clear), WW'(0));
        checkOutput({phase, "_res_valid"}, WW'(res_valid), WW'(0));
        checkOutput({phase, "_frame_done"}, WW'(frame_done), WW'(0));
    endtask

    initial begin
        rst        = 1'b1;
        pix_valid  = 1'b0;
        pix_data   = 8'd0;
        conv_done  = 1'b0;
        conv_pixel = 8'd0;
        res_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("por");
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", WW'(pix_ready), WW'(1));

        $display("[TB] frame with 3-cycle engine and ready downstream");
        applyStimulus(16, 3, 0, 4, 0);

        $display("[TB] frame with 20-cycle engine and 10-cycle result stall");
        applyStimulus(16, 20, 10, 4, 0);

        $display("[TB] reset during WAIT");
        applyStimulus(16, 20, 0, 0, 5);
        rst = 1'b1;
        #1;
        checkResetOutputs("mid");
        conv_done = 1'b0;
        pix_valid = 1'b0;
        busy_cnt  = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(16, 3, 0, 4, 0);

        $display("[TB] two back-to-back frames");
        applyStimulus(32, 3, 0, 8, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_window_sequencer.md
# conv_window_sequencer

Front-end driver for the serial convolution engine. Accepts a raster-order 8-bit pixel stream, buffers the most recent rows, and assembles each complete K×K window. For every window it issues a start to the engine, holds the window stable until the engine reports done, then pulses the engine's accumulator clear. It forwards the filtered pixel downstream on a valid/ready handshake, producing the valid-region (no padding) output image, (IMG_W-K+1)×(IMG_H-K+1) pixels per frame.

## Interface
- K, 3, window edge length (≥2); matches the engine's MAX_KERNEL
- IMG_W, 8, input image width in pixels (≥K)
- IMG_H, 8, input image height in pixels (≥K)
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- pix_valid  in  1  input pixel available
- pix_data  in  8  input pixel, raster order (row 0 col 0 first)
- pix_ready  out  1  sequencer accepts pix_data this cycle
- win_out  out  K*K*8  packed [K-1:0][K-1:0][7:0] window to engine; [y][x], y=0 oldest row, x=0 leftmost column
- conv_start  out  1  one-cycle start pulse to engine
- conv_done  in  1  engine finished current window (pulse)
- conv_pixel  in  8  engine result, sampled when conv_done
- conv_clear  out  1  one-cycle accumulator clear pulse to engine
- res_valid  out  1  filtered pixel available
- res_data  out  8  filtered pixel
- res_x  out  $clog2(IMG_W)  output column of res_data (0-based, valid region)
- res_y  out  $clog2(IMG_H)  output row of res_data
- res_ready  in  1  downstream accepts result
- frame_done  out  1  one-cycle pulse when last result of a frame is accepted

## Operation
- States: FILL, START, WAIT, CLEAR, OUT.
- FILL: pix_ready=1. A pixel is accepted when pix_valid&&pix_ready.
  - On accept at (row r, col c), the window shifts left one column. The new rightmost column is [linebuf rows r-K+1..r-1 at col c, pix_data]. The line buffers store pix_data at col c.
  - c increments, wrapping to 0 with r+1 at IMG_W-1.
  - If r≥K-1 and c≥K-1, go to START. Otherwise stay in FILL.
  - Windows with c<K-1 straddle a row boundary and are never issued.
- START: conv_start=1 for exactly one cycle, then go to WAIT.
- WAIT: win_out is held constant. On conv_done, capture conv_pixel into res_data, then go to CLEAR. conv_done is ignored in every other state.
- CLEAR: conv_clear=1 for one cycle, then go to OUT.
- OUT: res_valid=1, with res_x=c-K+1 and res_y=r-K+1 of the triggering pixel.
  - On res_ready, if this was pixel (IMG_H-1, IMG_W-1): pulse frame_done, reset r and c to 0, and return to FILL. The next frame starts clean; no stale row is used, because r<K-1 blocks issue.
  - Otherwise return to FILL.
- pix_ready=0 in every state except FILL; the input is back-pressured while the engine runs.
- win_out is a registered output and changes only on an accepted pixel.
- Counters: c runs 0..IMG_W-1 and r runs 0..IMG_H-1, wrapping exactly at the bounds with no overflow past the max.

## Timing
- Reset (async, immediate): state=FILL, r=c=0, window and line buffers=0. Output reset values: win_out=0, res_data=0, res_x=res_y=0, conv_start=0, conv_clear=0, res_valid=0, frame_done=0. pix_ready=1 once rst deasserts.
- Reset mid-operation (any state) abandons the window and the pending result. The engine is not cleared by this block; conv_clear is not pulsed.
- Window-completing pixel accepted at edge t: conv_start high during cycle t+1; WAIT from t+2.
- conv_done high in cycle d while in WAIT: res_data valid at edge d+1, conv_clear high during d+1, res_valid high from d+2.
- res_valid stays high, with res_data/res_x/res_y stable, until res_ready. With res_ready held high, the result is accepted in its first OUT cycle and pix_ready is high the following cycle.
- conv_done coincident with conv_start (START state) is ignored. A second conv_done in CLEAR/OUT is ignored.
- Minimum cost per output: 5 cycles plus engine latency. Non-issuing pixels take 1 cycle each.

## Test plan
- K=3, IMG_W=IMG_H=4, pixels 1..16, conv_done 3 cycles after each conv_start returning 50,60,70,80, res_ready=1. Required: exactly 4 conv_start pulses, after pixels 11, 12, 15 and 16. Windows are {1,2,3/5,6,7/9,10,11}, {2,3,4/6,7,8/10,11,12}, {5,6,7/9,10,11/13,14,15} and {6,7,8/10,11,12/14,15,16}. Results are 50@(0,0), 60@(1,0), 70@(0,1), 80@(1,1). frame_done pulses once, with the last accept.
- Same frame with pixels 13 and 14: accepted with no conv_start; pix_ready stays 1 across them.
- Hold res_ready=0 for 10 cycles on the first result. Required: res_valid, res_data=50 and res_x/res_y stable; pix_ready=0; no new conv_start.
- Stretch conv_done to 20 cycles. Required: win_out unchanged for the whole WAIT, pix_ready=0, exactly one conv_clear pulse, after done.
- Assert rst during WAIT, then stream a fresh frame 1..16. Required: all outputs return to their reset values immediately, and the first conv_start occurs after pixel 11 with window {1,2,3/5,6,7/9,10,11}.
- Two back-to-back frames. Required: 8 results total, two frame_done pulses, and the second frame's first window contains no first-frame pixels.
